// File: rtl/statmch_sum_collect.sv
// Captures one sum per rising edge of the upstream summer's ready into a small FIFO,
// serves it through a valid/ack handshake and keeps running capture statistics.
module statmch_sum_collect #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          ready_in,
    input  logic [7:0]    sum_in,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ack,
    output logic [7:0]    count,
    output logic [15:0]   total,
    output logic [7:0]    max_sum,
    output logic          overflow,
    output logic [AW:0]   level
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    state_t          state;
    state_t          state_n;
    logic            rdy_q;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_n;
    logic [7:0]      data_n;
    logic            cap;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {9'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (b > a) ? b : a;
    endfunction

    assign out_valid = (state == HOLD);
    assign cap       = ready_in & ~rdy_q;
    assign full      = (level == FULL_LVL);
    assign pop       = out_valid & out_ack;
    assign push      = cap & (~full | pop);
    assign drop      = cap & full & ~pop;

    always_comb begin
        level_n = level;
        if (push && !pop) begin
            level_n = level + (AW + 1)'(1);
        end else if (pop && !push) begin
            level_n = level - (AW + 1)'(1);
        end
    end

    // The head register is loaded from the incoming sum whenever the pushed
    // value becomes the head; otherwise from the entry behind the popped one.
    always_comb begin
        data_n = out_data;
        if (level_n != '0) begin
            if (level == '0 || (pop && level == (AW + 1)'(1))) begin
                data_n = sum_in;
            end else if (pop) begin
                data_n = mem[rd_ptr + AW'(1)];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   if (push) state_n = HOLD;
            HOLD:    if (pop && level_n == '0) state_n = EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sum_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            rdy_q    <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            out_data <= '0;
        end else begin
            state    <= state_n;
            rdy_q    <= ready_in;
            level    <= level_n;
            out_data <= data_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Statistics: clr takes priority over a coincident capture.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count    <= '0;
            total    <= '0;
            max_sum  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                count   <= sat_inc8(count);
                total   <= sat_add16(total, sum_in);
                max_sum <= max8(max_sum, sum_in);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_statmch_sum_collect.sv
// Directed bench for statmch_sum_collect: table-driven fill/drain plus hand-written corner sequences.
module tb_statmch_sum_collect;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        ready_in;
    logic [7:0]  sum_in;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ack;
    logic [7:0]  count;
    logic [15:0] total;
    logic [7:0]  max_sum;
    logic        overflow;
    logic [2:0]  level;

    int passed = 0;
    int checks = 0;

    statmch_sum_collect #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .ready_in  (ready_in),
        .sum_in    (sum_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .count     (count),
        .total     (total),
        .max_sum   (max_sum),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [7:0]  sum;
        logic        ack;
        logic        ev;
        logic [7:0]  ed;
        logic [2:0]  el;
        logic [7:0]  ec;
        logic [15:0] et;
        logic [7:0]  em;
        logic        eo;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic capture(input logic [7:0] v);
        ready_in = 1'b1;
        sum_in   = v;
        tick();
        ready_in = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; ready_in = 1'b1; sum_in = 8'h00; out_ack = 1'b0;

        // Reset released with ready_in already high: no capture
        tick(); tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("rst_count",    count, 0);
        check("rst_valid",    out_valid, 0);
        check("rst_level",    level, 0);
        check("rst_data",     out_data, 0);
        check("rst_total",    total, 0);
        check("rst_max",      max_sum, 0);
        check("rst_overflow", overflow, 0);
        ready_in = 1'b0;
        tick();

        // Long ready level yields a single capture, visible one cycle after cap
        ready_in = 1'b1; sum_in = 8'h2A;
        tick();
        check("long_valid", out_valid, 1);
        check("long_data",  out_data, 8'h2A);
        check("long_level", level, 1);
        tick(); tick(); tick(); tick();
        check("long_count", count, 1);
        check("long_total", total, 16'h002A);
        check("long_max",   max_sum, 8'h2A);
        check("long_level_held", level, 1);
        ready_in = 1'b0;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("long_drained", out_valid, 0);
        do_reset();

        // Fill past full, then drain in order
        vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 3'd1, 8'd1, 16'h0010, 8'h10, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 3'd1, 8'd1, 16'h0010, 8'h10, 1'b0};
        vecs[2]  = '{1'b1, 8'h20, 1'b0, 1'b1, 8'h10, 3'd2, 8'd2, 16'h0030, 8'h20, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 3'd2, 8'd2, 16'h0030, 8'h20, 1'b0};
        vecs[4]  = '{1'b1, 8'h30, 1'b0, 1'b1, 8'h10, 3'd3, 8'd3, 16'h0060, 8'h30, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 3'd3, 8'd3, 16'h0060, 8'h30, 1'b0};
        vecs[6]  = '{1'b1, 8'h40, 1'b0, 1'b1, 8'h10, 3'd4, 8'd4, 16'h00A0, 8'h40, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 3'd4, 8'd4, 16'h00A0, 8'h40, 1'b0};
        vecs[8]  = '{1'b1, 8'h50, 1'b0, 1'b1, 8'h10, 3'd4, 8'd4, 16'h00A0, 8'h40, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 3'd4, 8'd4, 16'h00A0, 8'h40, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 3'd3, 8'd4, 16'h00A0, 8'h40, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 3'd2, 8'd4, 16'h00A0, 8'h40, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 3'd1, 8'd4, 16'h00A0, 8'h40, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 8'd4, 16'h00A0, 8'h40, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 8'd4, 16'h00A0, 8'h40, 1'b1};
        for (int i = 0; i < 15; i++) begin
            ready_in = vecs[i].rdy;
            sum_in   = vecs[i].sum;
            out_ack  = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
            if (vecs[i].ev) check($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
            check($sformatf("vec%0d_level", i), level, vecs[i].el);
            check($sformatf("vec%0d_count", i), count, vecs[i].ec);
            check($sformatf("vec%0d_total", i), total, vecs[i].et);
            check($sformatf("vec%0d_max", i), max_sum, vecs[i].em);
            check($sformatf("vec%0d_overflow", i), overflow, vecs[i].eo);
        end
        out_ack = 1'b0;
        do_reset();

        // Full FIFO with capture and ack in the same cycle: no drop
        capture(8'h01); capture(8'h02); capture(8'h03); capture(8'h04);
        check("full_level", level, 4);
        ready_in = 1'b1; sum_in = 8'h77; out_ack = 1'b1;
        tick();
        ready_in = 1'b0;
        check("fullpp_overflow", overflow, 0);
        check("fullpp_level", level, 4);
        check("fullpp_data0", out_data, 8'h02);
        tick();
        check("fullpp_data1", out_data, 8'h03);
        tick();
        check("fullpp_data2", out_data, 8'h04);
        tick();
        check("fullpp_data3", out_data, 8'h77);
        check("fullpp_valid3", out_valid, 1);
        tick();
        check("fullpp_empty", out_valid, 0);
        check("fullpp_count", count, 5);
        out_ack = 1'b0;
        do_reset();

        // Saturation of count and total
        out_ack = 1'b1;
        for (int i = 0; i < 258; i++) capture(8'hFF);
        tick();
        out_ack = 1'b0;
        check("sat_count",    count, 8'd255);
        check("sat_total",    total, 16'hFFFF);
        check("sat_max",      max_sum, 8'hFF);
        check("sat_overflow", overflow, 0);
        check("sat_level",    level, 0);

        // clr coincident with a capture: stats cleared, push still happens
        capture(8'h09);
        check("pre_clr_count", count, 8'd255);
        ready_in = 1'b1; sum_in = 8'h05; clr = 1'b1;
        tick();
        ready_in = 1'b0; clr = 1'b0;
        check("clr_count",    count, 0);
        check("clr_total",    total, 0);
        check("clr_max",      max_sum, 0);
        check("clr_overflow", overflow, 0);
        check("clr_level",    level, 2);
        check("clr_head",     out_data, 8'h09);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("clr_pushed_data",  out_data, 8'h05);
        check("clr_pushed_valid", out_valid, 1);
        check("clr_pushed_level", level, 1);

        // Reset mid-operation discards FIFO content
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_level", level, 0);
        check("midrst_data",  out_data, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
